conv_sequencer: RTL

Control FSM that sequences the 3x3 convolution datapath over a loaded image, one output position at a time. For every tap it issues:
- image-buffer pixel address and zero-pad flag
- weight index
- accumulator control: clear, enable, filter select
It then presents each finished output position to the downstream pipeline with a valid/ready handshake. It sits between the image loader (img_ready) and the conv MAC/ReLU stage, and replaces free-running counters inside the datapath.

---
 rtl/conv_sequencer_if.sv | 60 ++++++
 rtl/conv_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sequencer_if.sv
// conv_sequencer_if
// Bundles the control/handshake signals between the convolution sequencer and
// its surroundings (image loader, MAC/ReLU datapath, downstream emit stage).
//
// Modports:
//   master - the sequencer: samples start/abort/img_ready/emit_ready and
//            drives busy, tap decode (pix_addr, pad, w_idx), accumulator
//            control (acc_sel, acc_clr, acc_en), emit_valid, pos_idx, done.
//   slave  - the environment driving the requests and consuming the controls.
//
// Build option: CONV_SEQ_PERF_EN adds perf_cycles and stall_cycles.
interface conv_sequencer_if #(
    parameter int AW          = 6,
    parameter int NUM_FILTERS = 2
);
    localparam int SELW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

    logic            start;
    logic            abort;
    logic            img_ready;
    logic            busy;
    logic [AW-1:0]   pix_addr;
    logic            pad;
    logic [4:0]      w_idx;
    logic [SELW-1:0] acc_sel;
    logic            acc_clr;
    logic            acc_en;
    logic            emit_valid;
    logic            emit_ready;
    logic [5:0]      pos_idx;
    logic            done;
`ifdef CONV_SEQ_PERF_EN
    logic [15:0]     perf_cycles;
    logic [15:0]     stall_cycles;

    modport master (
        input  start, abort, img_ready, emit_ready,
        output busy, pix_addr, pad, w_idx, acc_sel, acc_clr, acc_en,
        output emit_valid, pos_idx, done, perf_cycles, stall_cycles
    );

    modport slave (
        output start, abort, img_ready, emit_ready,
        input  busy, pix_addr, pad, w_idx, acc_sel, acc_clr, acc_en,
        input  emit_valid, pos_idx, done, perf_cycles, stall_cycles
    );
`else
    modport master (
        input  start, abort, img_ready, emit_ready,
        output busy, pix_addr, pad, w_idx, acc_sel, acc_clr, acc_en,
        output emit_valid, pos_idx, done
    );

    modport slave (
        output start, abort, img_ready, emit_ready,
        input  busy, pix_addr, pad, w_idx, acc_sel, acc_clr, acc_en,
        input  emit_valid, pos_idx, done
    );
`endif
endinterface

// File: rtl/conv_sequencer.sv
// conv_sequencer
// Control FSM stepping the 3x3 convolution datapath across a loaded image, one
// output position at a time. Each RUN cycle issues one tap (pixel address or
// zero-pad, weight index, accumulator control); after every filter of the
// position has seen all nine taps, the position is offered downstream with a
// valid/ready handshake (EMIT). The last accepted position produces a one-cycle
// done pulse.
//
// Ports:
//   clk    - clock
//   reset  - synchronous active-high reset; aborts any frame immediately
//   bus    - conv_sequencer_if.master:
//            in : start, abort, img_ready, emit_ready
//            out: busy, pix_addr, pad, w_idx, acc_sel, acc_clr, acc_en,
//                 emit_valid, pos_idx, done
//
// Build option: CONV_SEQ_PERF_EN adds bus.perf_cycles (busy cycles) and
// bus.stall_cycles (EMIT cycles with emit_ready low), both saturating, cleared
// on reset and on start acceptance, held after the frame.
module conv_sequencer #(
    parameter int IMG_W       = 8,
    parameter int IMG_H       = 8,
    parameter int OUT_W       = 6,
    parameter int OUT_H       = 6,
    parameter int NUM_FILTERS = 2,
    parameter int AW          = 6
) (
    input  logic             clk,
    input  logic             reset,
    conv_sequencer_if.master bus
);
    localparam int SELW    = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int NPOS    = OUT_W * OUT_H;
    localparam int IMG_MAX = (IMG_W > IMG_H) ? IMG_W : IMG_H;
    // Signed tap coordinates need room for -1 and for IMG_MAX itself.
    localparam int CW_MIN  = $clog2(IMG_MAX + 1) + 2;
    localparam int CW      = (CW_MIN > 5) ? CW_MIN : 5;
    localparam int XW      = CW - 1;

    localparam logic signed [CW-1:0] IMG_W_S   = CW'(IMG_W);
    localparam logic signed [CW-1:0] IMG_H_S   = CW'(IMG_H);
    localparam logic [AW-1:0]        IMG_W_A   = AW'(IMG_W);
    localparam logic [5:0]           LAST_POS  = 6'(NPOS - 1);
    localparam logic [SELW-1:0]      LAST_FILT = SELW'(NUM_FILTERS - 1);
    localparam logic [XW-1:0]        LAST_X    = XW'(OUT_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_EMIT,
        S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [5:0]      pos, pos_nxt;
    logic [SELW-1:0] filt, filt_nxt;
    logic [3:0]      tap, tap_nxt;
    // Center coordinates of the current position, tracked alongside pos so the
    // datapath never needs a divide by OUT_W.
    logic [XW-1:0]   cx, cx_nxt;
    logic [XW-1:0]   cy, cy_nxt;

    logic signed [CW-1:0] px, py;
    logic                 pad_c;
    logic [AW-1:0]        lin_addr;
    logic                 in_run;

    // Column offset of a tap within the 3x3 window: tap % 3 - 1.
    function automatic logic signed [CW-1:0] tap_col_offset(input logic [3:0] t);
        logic signed [CW-1:0] d;
        case (t)
            4'd0, 4'd3, 4'd6: d = '1;
            4'd2, 4'd5, 4'd8: d = CW'(1);
            default:          d = '0;
        endcase
        return d;
    endfunction

    // Row offset of a tap within the 3x3 window: tap / 3 - 1.
    function automatic logic signed [CW-1:0] tap_row_offset(input logic [3:0] t);
        logic signed [CW-1:0] d;
        case (t)
            4'd0, 4'd1, 4'd2: d = '1;
            4'd6, 4'd7, 4'd8: d = CW'(1);
            default:          d = '0;
        endcase
        return d;
    endfunction

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            pos   <= '0;
            filt  <= '0;
            tap   <= '0;
            cx    <= '0;
            cy    <= '0;
        end else begin
            state <= state_nxt;
            pos   <= pos_nxt;
            filt  <= filt_nxt;
            tap   <= tap_nxt;
            cx    <= cx_nxt;
            cy    <= cy_nxt;
        end
    end

    // Next-state and counter sequencing
    always_comb begin
        state_nxt = state;
        pos_nxt   = pos;
        filt_nxt  = filt;
        tap_nxt   = tap;
        cx_nxt    = cx;
        cy_nxt    = cy;

        if (bus.abort) begin
            // Abort beats everything, including a simultaneous start in IDLE.
            state_nxt = S_IDLE;
            pos_nxt   = '0;
            filt_nxt  = '0;
            tap_nxt   = '0;
            cx_nxt    = '0;
            cy_nxt    = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    pos_nxt  = '0;
                    filt_nxt = '0;
                    tap_nxt  = '0;
                    cx_nxt   = '0;
                    cy_nxt   = '0;
                    if (bus.start) begin
                        state_nxt = S_ARM;
                    end
                end
                S_ARM: begin
                    if (bus.img_ready) begin
                        state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (tap == 4'd8) begin
                        tap_nxt = '0;
                        if (filt == LAST_FILT) begin
                            filt_nxt  = '0;
                            state_nxt = S_EMIT;
                        end else begin
                            filt_nxt = filt + SELW'(1);
                        end
                    end else begin
                        tap_nxt = tap + 4'd1;
                    end
                end
                S_EMIT: begin
                    if (bus.emit_ready) begin
                        if (pos == LAST_POS) begin
                            state_nxt = S_DONE;
                        end else begin
                            state_nxt = S_RUN;
                            pos_nxt   = pos + 6'd1;
                            if (cx == LAST_X) begin
                                cx_nxt = '0;
                                cy_nxt = cy + XW'(1);
                            end else begin
                                cx_nxt = cx + XW'(1);
                            end
                        end
                    end
                end
                S_DONE: begin
                    // Leave IDLE with clean counters so pos_idx reads 0 there.
                    state_nxt = S_IDLE;
                    pos_nxt   = '0;
                    filt_nxt  = '0;
                    tap_nxt   = '0;
                    cx_nxt    = '0;
                    cy_nxt    = '0;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Tap decode: neighbour coordinate, pad test and linear address
    always_comb begin
        px       = $signed({1'b0, cx}) + tap_col_offset(tap);
        py       = $signed({1'b0, cy}) + tap_row_offset(tap);
        // Sign bit catches -1; the upper bound test stops wrap into the next row.
        pad_c    = px[CW-1] || py[CW-1] || (px >= IMG_W_S) || (py >= IMG_H_S);
        lin_addr = AW'($unsigned(py)) * IMG_W_A + AW'($unsigned(px));
    end

    assign in_run         = (state == S_RUN);
    assign bus.busy       = (state != S_IDLE);
    assign bus.pad        = in_run && pad_c;
    assign bus.pix_addr   = (in_run && !pad_c) ? lin_addr : '0;
    assign bus.w_idx      = in_run ? (5'(filt) * 5'd9 + 5'(tap)) : '0;
    assign bus.acc_sel    = in_run ? filt : '0;
    assign bus.acc_clr    = in_run && (tap == 4'd0);
    assign bus.acc_en     = in_run;
    assign bus.emit_valid = (state == S_EMIT);
    assign bus.pos_idx    = pos;
    assign bus.done       = (state == S_DONE);

`ifdef CONV_SEQ_PERF_EN
    logic [15:0] perf_cnt;
    logic [15:0] stall_cnt;
    logic        start_accept;

    assign start_accept = (state == S_IDLE) && bus.start && !bus.abort;

    // Performance counters
    always_ff @(posedge clk) begin
        if (reset || start_accept) begin
            perf_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if ((state != S_IDLE) && (perf_cnt != 16'hFFFF)) begin
                perf_cnt <= perf_cnt + 16'd1;
            end
            if ((state == S_EMIT) && !bus.emit_ready && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    assign bus.perf_cycles  = perf_cnt;
    assign bus.stall_cycles = stall_cnt;
`endif
endmodule
